// File: rtl/mux_8x1_rr.sv
// 8-input round-robin merge mux with a single registered output stage and source tag.
// Optional packet lock (in_last/out_last ports) is enabled by defining MUX_PKT_LOCK_EN.
module mux_8x1_rr #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_valid,
  input  logic [8*DATA_W-1:0] in_data,
  output logic [7:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_sel,
  input  logic                out_ready
`ifdef MUX_PKT_LOCK_EN
  ,
  input  logic [7:0]          in_last,
  output logic                out_last
`endif
);

  // Handshake: a word moves on a rising edge where valid and ready are both 1.
  // Upstream ready is one-hot toward the granted channel and only when the
  // output register can load (empty, or its word leaves this same cycle).

  logic [2:0]        ptr;
  logic              load;
  logic              take;
  logic              any_valid;
  logic              rr_found;
  logic [2:0]        rr_grant;
  logic [2:0]        grant;
  logic [DATA_W-1:0] grant_data;

  // Rotating-priority search starting at ptr.
  always_comb begin : rr_search
    logic [2:0] idx;
    idx      = ptr;
    rr_found = 1'b0;
    rr_grant = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!rr_found && in_valid[idx]) begin
        rr_found = 1'b1;
        rr_grant = idx;
      end
    end
  end

`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t lock_q;
  lock_state_t lock_d;
  logic [2:0]  lock_ch;

  always_comb begin
    if (lock_q == LOCKED) begin
      grant     = lock_ch;
      any_valid = in_valid[lock_ch];
    end else begin
      grant     = rr_grant;
      any_valid = rr_found;
    end
  end

  // Lock holds from a non-last beat until the last beat of that packet moves.
  always_comb begin
    lock_d = lock_q;
    if (take) begin
      lock_d = in_last[grant] ? ARB : LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= ARB;
      lock_ch <= 3'd0;
    end else begin
      lock_q <= lock_d;
      if (take) begin
        lock_ch <= grant;
      end
    end
  end
`else
  always_comb begin
    grant     = rr_grant;
    any_valid = rr_found;
  end
`endif

  assign load       = ~out_valid | out_ready;
  assign take       = ~rst & load & any_valid;
  assign in_ready   = take ? (8'b0000_0001 << grant) : 8'b0000_0000;
  assign grant_data = in_data[32'(grant)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      ptr       <= 3'd0;
`ifdef MUX_PKT_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (load) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
`ifdef MUX_PKT_LOCK_EN
        out_last  <= in_last[grant];
        // Pointer moves past a channel only once its whole packet is through.
        if (in_last[grant]) begin
          ptr <= grant + 3'd1;
        end
`else
        ptr       <= grant + 3'd1;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_8x1_rr.sv
// Directed bench for mux_8x1_rr: hand-computed expected words queued by the
// stimulus, popped by a monitor on every output transfer.
module tb_mux_8x1_rr;
  localparam int DW = 8;
  localparam int W  = 12;  // {last, sel[2:0], data[7:0]}
`ifdef MUX_PKT_LOCK_EN
  localparam logic LST = 1'b1;
`else
  localparam logic LST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      in_valid;
  logic [8*DW-1:0] in_data;
  logic [7:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_sel;
  logic            out_ready;
`ifdef MUX_PKT_LOCK_EN
  logic [7:0]      in_last;
  logic            out_last;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mux_8x1_rr #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
`ifdef MUX_PKT_LOCK_EN
    ,
    .in_last  (in_last),
    .out_last (out_last)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    in_data[ch*DW +: DW] = d;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) begin
      set_ch(i, 8'hA0 + 8'(i));
    end
  endtask

  task automatic expect_word(input logic last, input logic [2:0] sel, input logic [7:0] d);
    exp_q.push_back({last, sel, d});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
`ifdef MUX_PKT_LOCK_EN
      mon_act = {out_last, out_sel, out_data};
`else
      mon_act = {1'b0, out_sel, out_data};
`endif
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_word", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    in_data   = '0;
    load_ramp();
`ifdef MUX_PKT_LOCK_EN
    in_last   = 8'hFF;
`endif

    // reset with all channels valid
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sel", 32'(out_sel), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    tick();
    check("rst_in_ready2", 32'(in_ready), 0);
    check("rst_out_valid2", 32'(out_valid), 0);
    rst = 1'b0;

    // full-rate round robin 0..7,0
    for (int i = 0; i < 8; i++) begin
      expect_word(LST, 3'(i), 8'hA0 + 8'(i));
    end
    expect_word(LST, 3'd0, 8'hA0);
    repeat (9) tick();
    in_valid = 8'h00;
    tick();
    check("t2_drained", 32'(out_valid), 0);

    // ch5 alone with output back-pressure
    set_ch(5, 8'h55);
    in_valid  = 8'h20;
    out_ready = 1'b0;
    tick();
    set_ch(5, 8'h56);
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_data", 32'(out_data), 32'h55);
      check("t3_hold_sel", 32'(out_sel), 5);
      check("t3_hold_ready", 32'(in_ready), 0);
      tick();
    end
    expect_word(LST, 3'd5, 8'h55);
    expect_word(LST, 3'd5, 8'h56);
    out_ready = 1'b1;
    tick();
    in_valid = 8'h00;
    tick();
    check("t3_drained", 32'(out_valid), 0);

    // ch2 + ch6 with ptr moved to 3
    set_ch(2, 8'h22);
    set_ch(6, 8'h66);
    in_valid = 8'h04;
    expect_word(LST, 3'd2, 8'h22);
    tick();
    in_valid = 8'h44;
    #1;
    check("t4_ready_ch6", 32'(in_ready), 32'h40);
    expect_word(LST, 3'd6, 8'h66);
    expect_word(LST, 3'd2, 8'h22);
    expect_word(LST, 3'd6, 8'h66);
    tick();
    tick();
    tick();
    in_valid = 8'h00;
    tick();
    check("t4_drained", 32'(out_valid), 0);

    // reset while a word is held: word dropped, ptr back to 0
    set_ch(3, 8'h33);
    in_valid  = 8'h08;
    out_ready = 1'b0;
    tick();
    in_valid = 8'h00;
    check("t5_held_valid", 32'(out_valid), 1);
    check("t5_held_sel", 32'(out_sel), 3);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_sel", 32'(out_sel), 0);
    check("t5_rst_data", 32'(out_data), 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    load_ramp();
    in_valid = 8'h81;
    expect_word(LST, 3'd0, 8'hA0);
    expect_word(LST, 3'd7, 8'hA7);
    tick();
    in_valid = 8'h80;
    tick();
    in_valid = 8'h00;
    tick();
    check("t5_drained", 32'(out_valid), 0);

`ifdef MUX_PKT_LOCK_EN
    // ch1 three-beat packet while ch0 stays valid
    set_ch(0, 8'h0A);
    in_last  = 8'hFF;
    in_valid = 8'h01;
    expect_word(1'b1, 3'd0, 8'h0A);
    tick();
    set_ch(0, 8'h0B);
    set_ch(1, 8'h11);
    in_last[1] = 1'b0;
    in_valid   = 8'h03;
    expect_word(1'b0, 3'd1, 8'h11);
    tick();
    set_ch(1, 8'h12);
    in_valid = 8'h01;
    #1;
    check("t6_lock_stall_ready", 32'(in_ready), 0);
    tick();
    check("t6_lock_stall_valid", 32'(out_valid), 0);
    in_valid = 8'h03;
    expect_word(1'b0, 3'd1, 8'h12);
    tick();
    set_ch(1, 8'h13);
    in_last[1] = 1'b1;
    expect_word(1'b1, 3'd1, 8'h13);
    tick();
    in_valid = 8'h01;
    expect_word(1'b1, 3'd0, 8'h0B);
    tick();
    in_valid = 8'h00;
    tick();
    check("t6_drained", 32'(out_valid), 0);
`endif

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
